// File: rtl/uart_order_tx_if.sv
// uart_order_tx_if: host order handshake, UART byte-engine and verdict signals of the order sender
interface uart_order_tx_if;
    logic       order_valid_i;
    logic [2:0] order_id_i;
    logic       order_ready_o;
    logic       busy_o;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_done_i;
    logic [7:0] rx_data_i;
    logic       rx_done_i;
    logic       resp_valid_o;
    logic [1:0] resp_code_o;
    logic [7:0] resp_byte_o;

    modport slave (
        input  order_valid_i, order_id_i, tx_done_i, rx_data_i, rx_done_i,
        output order_ready_o, busy_o, tx_data_o, tx_start_o, resp_valid_o, resp_code_o, resp_byte_o
    );

    modport master (
        output order_valid_i, order_id_i, tx_done_i, rx_data_i, rx_done_i,
        input  order_ready_o, busy_o, tx_data_o, tx_start_o, resp_valid_o, resp_code_o, resp_byte_o
    );
endinterface

// File: rtl/uart_order_tx.sv
// uart_order_tx: sends the FF 00 00 0N order frame to the UART transmitter and classifies the verdict byte
module uart_order_tx #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    uart_order_tx_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_TX   = 3'd2;
    localparam logic [2:0] WAIT_RESP = 3'd3;
    localparam logic [2:0] REPORT    = 3'd4;

    logic [2:0]    r_state;
    logic [1:0]    r_idx;
    logic [2:0]    r_id;
    logic [7:0]    r_tx_data;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_code;
    logic [7:0]    r_byte;
    logic [7:0]    w_next_byte;
    logic          w_expire;

    // frame bytes 1 and 2 are zero; byte 3 carries the id
    assign w_next_byte       = (r_idx == 2'd2) ? {5'b0, r_id} : 8'h00;
    assign w_expire          = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign bus.order_ready_o = r_state == IDLE;
    assign bus.busy_o        = r_state != IDLE;
    assign bus.tx_start_o    = r_state == SEND;
    assign bus.resp_valid_o  = r_state == REPORT;
    assign bus.tx_data_o     = r_tx_data;
    assign bus.resp_code_o   = r_code;
    assign bus.resp_byte_o   = r_byte;

    // order FSM: byte sequencing, verdict capture and timeout counting
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_idx     <= 2'd0;
            r_id      <= 3'd0;
            r_tx_data <= 8'h00;
            r_cnt     <= '0;
            r_code    <= 2'b00;
            r_byte    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: if (bus.order_valid_i) begin
                    r_id      <= bus.order_id_i;
                    r_idx     <= 2'd0;
                    r_tx_data <= 8'hFF;
                    r_state   <= SEND;
                end
                SEND: r_state <= WAIT_TX;
                WAIT_TX: if (bus.tx_done_i) begin
                    if (r_idx == 2'd3) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_RESP;
                    end else begin
                        r_idx     <= r_idx + 2'd1;
                        r_tx_data <= w_next_byte;
                        r_state   <= SEND;
                    end
                end
                WAIT_RESP: begin
                    if (!w_expire) r_cnt <= r_cnt + CW'(1);
                    if (bus.rx_done_i) begin
                        r_byte  <= bus.rx_data_i;
                        r_code  <= (bus.rx_data_i == 8'hAA) ? 2'b00 : (bus.rx_data_i == 8'hCC) ? 2'b01 : 2'b10;
                        r_state <= REPORT;
                    end else if (w_expire) begin
                        r_code  <= 2'b11;
                        r_byte  <= 8'h00;
                        r_state <= REPORT;
                    end
                end
                REPORT: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_order_tx.sv
// tb_uart_order_tx: directed scoreboard bench for the UART order sender
module tb_uart_order_tx;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] txq[$];
    logic [9:0] rspq[$];
    int cnt;

    uart_order_tx_if bus();

    uart_order_tx #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // every tx_start_o must match the next expected frame byte
    always @(negedge clk) begin
        if (rst_n && bus.tx_start_o) begin
            if (txq.size() == 0) chk("tx_unexpected", 32'(bus.tx_start_o), 32'd0);
            else chk("tx_byte", 32'(bus.tx_data_o), 32'(txq.pop_front()));
        end
    end

    // every resp_valid_o must match the next expected verdict
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid_o) begin
            if (rspq.size() == 0) chk("resp_unexpected", 32'(bus.resp_valid_o), 32'd0);
            else chk("resp", 32'({bus.resp_code_o, bus.resp_byte_o}), 32'(rspq.pop_front()));
        end
    end

    task automatic wait_start();
        int n = 0;
        while (!bus.tx_start_o && n < 50) begin
            tick();
            n++;
        end
        chk("tx_start_seen", 32'(bus.tx_start_o), 32'd1);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            wait_start();
            repeat (4) tick();
            bus.tx_done_i = 1'b1;
            tick();
            bus.tx_done_i = 1'b0;
        end
    endtask

    task automatic accept(input logic [2:0] id);
        int n = 0;
        while (!bus.order_ready_o && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_accept", 32'(bus.order_ready_o), 32'd1);
        txq.push_back(8'hFF);
        txq.push_back(8'h00);
        txq.push_back(8'h00);
        txq.push_back({5'b0, id});
        bus.order_valid_i = 1'b1;
        bus.order_id_i = id;
        tick();
        bus.order_valid_i = 1'b0;
        chk("start_latency", 32'(bus.tx_start_o), 32'd1);
        chk("busy_after_accept", 32'(bus.busy_o), 32'd1);
    endtask

    task automatic reply(input logic [7:0] b);
        bus.rx_data_i = b;
        bus.rx_done_i = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
        chk("resp_latency", 32'(bus.resp_valid_o), 32'd1);
        tick();
        chk("resp_one_pulse", 32'(bus.resp_valid_o), 32'd0);
        chk("ready_after_resp", 32'(bus.order_ready_o), 32'd1);
    endtask

    task automatic order(input logic [2:0] id, input logic [7:0] b, input logic [1:0] code);
        accept(id);
        rspq.push_back({code, b});
        send_bytes(4);
        repeat (3) tick();
        reply(b);
    endtask

    initial begin
        bus.order_valid_i = 1'b0;
        bus.order_id_i = 3'd0;
        bus.tx_done_i = 1'b0;
        bus.rx_data_i = 8'h00;
        bus.rx_done_i = 1'b0;
        repeat (3) tick();
        chk("rst_ready", 32'(bus.order_ready_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start_o), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data_o), 32'h00);
        chk("rst_resp", 32'({bus.resp_valid_o, bus.resp_code_o, bus.resp_byte_o}), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        order(3'd3, 8'hAA, 2'b00);
        order(3'd0, 8'hCC, 2'b01);
        order(3'd7, 8'h5A, 2'b10);

        accept(3'd4);
        rspq.push_back({2'b11, 8'h00});
        send_bytes(4);
        cnt = 1;
        while (!bus.resp_valid_o && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("timeout_cycles", 32'(cnt), 32'(T + 1));
        tick();
        chk("ready_after_timeout", 32'(bus.order_ready_o), 32'd1);

        accept(3'd1);
        rspq.push_back({2'b00, 8'hAA});
        send_bytes(4);
        repeat (T - 1) tick();
        reply(8'hAA);

        accept(3'd5);
        rspq.push_back({2'b01, 8'hCC});
        wait_start();
        tick();
        bus.rx_data_i = 8'hAA;
        bus.rx_done_i = 1'b1;
        tick();
        bus.rx_done_i = 1'b0;
        chk("stray_rx_ignored", 32'(bus.resp_valid_o), 32'd0);
        repeat (2) tick();
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        send_bytes(3);
        tick();
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        chk("extra_done_no_start", 32'(bus.tx_start_o), 32'd0);
        tick();
        chk("extra_done_no_start2", 32'(bus.tx_start_o), 32'd0);
        chk("extra_done_busy", 32'(bus.busy_o), 32'd1);
        reply(8'hCC);

        accept(3'd6);
        txq.delete();
        txq.push_back(8'hFF);
        txq.push_back(8'h00);
        txq.push_back(8'h00);
        send_bytes(2);
        wait_start();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.order_ready_o), 32'd1);
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_tx", 32'({bus.tx_start_o, bus.tx_data_o}), 32'd0);
        chk("abort_resp", 32'({bus.resp_valid_o, bus.resp_code_o, bus.resp_byte_o}), 32'd0);
        bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_reset_idle", 32'({bus.busy_o, bus.tx_start_o, bus.resp_valid_o}), 32'd0);

        order(3'd2, 8'hAA, 2'b00);

        repeat (3) tick();
        chk("txq_empty", 32'(txq.size()), 32'd0);
        chk("rspq_empty", 32'(rspq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
